// File: rtl/bip_uart_pkg.sv
// Shared constants and types for the UART program loader / BIP sequencer.
package bip_uart_pkg;

    // Sequencer states. The encoding is visible on the STATE debug port.
    typedef enum logic [2:0] {
        LOAD_LO = 3'd0,
        LOAD_HI = 3'd1,
        WRITE   = 3'd2,
        RUN     = 3'd3,
        TX_SEND = 3'd4,
        TX_WAIT = 3'd5
    } state_e;

    // Instruction word that ends a program download.
    localparam logic [15:0] HALT_WORD_DEF = 16'h0000;

    // Result frame returned to the host: acc lo, acc hi, cycles lo, cycles hi.
    localparam int          TX_BYTES   = 4;
    localparam logic [1:0]  IDX_ACC_LO = 2'd0;
    localparam logic [1:0]  IDX_ACC_HI = 2'd1;
    localparam logic [1:0]  IDX_CYC_LO = 2'd2;
    localparam logic [1:0]  IDX_CYC_HI = 2'd3;
    localparam logic [1:0]  IDX_LAST   = 2'(TX_BYTES - 1);

endpackage

// File: rtl/bip_uart_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; used for BIP execution cycles.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bip_uart_loader.sv
// Sequencer between the UART and the BIP core: download a program as
// little-endian 16-bit words, run it while counting cycles, then return the
// accumulator and cycle count as four bytes and re-arm for the next program.
module bip_uart_loader
    import bip_uart_pkg::*;
#(
    parameter int          N_BIT     = 8,
    parameter int          ADDR_W    = 11,
    parameter int          DEPTH     = 2048,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEF,
    parameter int          CYC_W     = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX_DONE,
    input  logic [N_BIT-1:0]  RX_DATA,
    input  logic              TX_DONE,
    output logic              TX_START,
    output logic [N_BIT-1:0]  TX_DATA,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DATA,
    output logic              BIP_EN,
    input  logic              BIP_HALT,
    input  logic [15:0]       ACC,
    output logic [2:0]        STATE
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [N_BIT-1:0]   lo_q,    lo_d;
    logic [N_BIT-1:0]   hi_q,    hi_d;
    logic [15:0]        acc_q,   acc_d;
    logic [1:0]         idx_q,   idx_d;
    logic               cyc_clr;
    logic               cyc_en;
    logic [CYC_W-1:0]   cyc;
    logic [15:0]        cyc16;
    logic [N_BIT-1:0]   tx_byte;

    // Execution cycle counter: cleared on entry to RUN, counts every RUN cycle.
    assign cyc_en = (state_q == RUN);

    sat_counter #(
        .W (CYC_W)
    ) u_cyc (
        .CLK   (CLK),
        .RESET (RESET),
        .clr_i (cyc_clr),
        .en_i  (cyc_en),
        .cnt_o (cyc)
    );

    assign cyc16 = 16'(cyc);

    // Next-state and datapath updates for the load / run / report sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cyc_clr = 1'b0;
        case (state_q)
            LOAD_LO: begin
                if (RX_DONE) begin
                    lo_d    = RX_DATA;
                    state_d = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (RX_DONE) begin
                    hi_d    = RX_DATA;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The halt word is itself written before the program starts.
                if (({hi_q, lo_q} == HALT_WORD) || (addr_q == ADDR_LAST)) begin
                    addr_d  = '0;
                    cyc_clr = 1'b1;
                    state_d = RUN;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD_LO;
                end
            end
            RUN: begin
                if (BIP_HALT) begin
                    acc_d   = ACC;
                    idx_d   = '0;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (TX_DONE) begin
                    if (idx_q == IDX_LAST) begin
                        addr_d  = '0;
                        state_d = LOAD_LO;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = TX_SEND;
                    end
                end
            end
            default: begin
                state_d = LOAD_LO;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= LOAD_LO;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Result byte selected by the frame index; held steady through TX_WAIT.
    always_comb begin
        tx_byte = '0;
        case (idx_q)
            IDX_ACC_LO: tx_byte = acc_q[7:0];
            IDX_ACC_HI: tx_byte = acc_q[15:8];
            IDX_CYC_LO: tx_byte = cyc16[7:0];
            IDX_CYC_HI: tx_byte = cyc16[15:8];
            default:    tx_byte = '0;
        endcase
    end

    // Moore outputs decoded from the current state only.
    assign MEM_WE   = (state_q == WRITE);
    assign BIP_EN   = (state_q == RUN);
    assign TX_START = (state_q == TX_SEND);
    assign MEM_ADDR = addr_q;
    assign MEM_DATA = {hi_q, lo_q};
    assign TX_DATA  = tx_byte;
    assign STATE    = state_q;

endmodule

// File: doc/bip_uart_loader.md
Name: bip_uart_loader

Overview:
Top-level sequencer between the UART (Rx/Tx) and the BIP core. It assembles received bytes into 16-bit instruction words and writes them into program memory. It then enables the BIP and counts execution cycles until halt. Finally it returns the accumulator and the cycle count to the host through the Tx handshake, then re-arms for the next program.

Parameters:
N_BIT, 8, UART data width; must be 8.
ADDR_W, 11, program memory address width.
DEPTH, 2048, program memory words; load stops at DEPTH-1.
HALT_WORD, 16'h0000, instruction word that terminates a load.
CYC_W, 16, cycle counter width; the counter saturates.

Ports:
CLK  in  1  clock.
RESET  in  1  reset, asynchronous, active-high.
RX_DONE  in  1  one-cycle pulse from the UART receiver; byte valid.
RX_DATA  in  N_BIT  received byte.
TX_DONE  in  1  one-cycle pulse; the transmitter finished a byte.
TX_START  out  1  one-cycle request to transmit TX_DATA.
TX_DATA  out  N_BIT  byte to transmit; stable from TX_START until TX_DONE.
MEM_WE  out  1  program memory write enable.
MEM_ADDR  out  ADDR_W  program memory address.
MEM_DATA  out  16  program memory write data, {hi,lo}.
BIP_EN  out  1  BIP run enable.
BIP_HALT  in  1  BIP executed a halt; level.
ACC  in  16  BIP accumulator.
STATE  out  3  current state encoding, for debug LEDs.

Behaviour:
- Moore FSM, 3-bit encoding: LOAD_LO=0, LOAD_HI=1, WRITE=2, RUN=3, TX_SEND=4, TX_WAIT=5.
- Reset state and register values:
  - State LOAD_LO; addr, lo, hi, acc_q, cyc and idx all 0.
  - All outputs 0; STATE=0.
- LOAD_LO: on RX_DATA pulse... on RX_DONE, lo<=RX_DATA and go to LOAD_HI. Otherwise hold.
- LOAD_HI: on RX_DONE, hi<=RX_DATA and go to WRITE. The word is little-endian: low byte first.
- WRITE (exactly one cycle): MEM_WE=1, MEM_ADDR=addr, MEM_DATA={hi,lo}. Next state depends on the word and address:
  - If {hi,lo}==HALT_WORD or addr==DEPTH-1: go to RUN, set addr<=0, cyc<=0. The halt word itself is written.
  - Otherwise: addr<=addr+1, go to LOAD_LO.
- RUN:
  - BIP_EN=1; cyc increments every RUN cycle, saturating at all-ones.
  - When BIP_HALT is sampled 1: latch acc_q<=ACC, set idx<=0, go to TX_SEND. The halt cycle is counted.
  - BIP_EN is 0 from the next cycle onward.
- TX_SEND (one cycle): TX_START=1. TX_DATA is selected by idx:
  - idx 0: acc_q[7:0]
  - idx 1: acc_q[15:8]
  - idx 2: cyc[7:0]
  - idx 3: cyc[15:8]
  - Then go to TX_WAIT.
- TX_WAIT: hold TX_DATA.
  - On TX_DONE with idx==3: go to LOAD_LO with addr=0.
  - On TX_DONE otherwise: idx<=idx+1 and go to TX_SEND.
- RX_DONE is ignored in WRITE, RUN, TX_SEND and TX_WAIT; bytes arriving then are dropped.
- TX_DONE outside TX_WAIT is ignored. BIP_HALT outside RUN is ignored.
- MEM_ADDR always drives addr; MEM_DATA always drives {hi,lo}. Only MEM_WE qualifies them.
- TX_START and MEM_WE are never high for more than one consecutive cycle.
- Latencies:
  - RX_DONE of the high byte to MEM_WE: 1 cycle.
  - BIP_HALT to TX_START: 1 cycle.
  - TX_DONE to the next TX_START: 1 cycle.
- Reset mid-operation: asynchronous return to the reset state. BIP_EN, MEM_WE and TX_START drop immediately; a partial word is discarded.
- TX_DONE never arriving: the FSM waits indefinitely; there is no timeout.

Decomposition:
- Package bip_uart_pkg holds:
  - state localparams (LOAD_LO..TX_WAIT);
  - HALT_WORD default;
  - TX_BYTES=4;
  - byte-index constants.
- One sub-module is natural: sat_counter (CYC_W wide, with clear, enable and saturate) for cyc.
- The address counter and the TX byte mux stay inline.

Test Plan:
- Load bytes 01 08 05 10 00 00 -> MEM_WE pulses write addr0=0x0801, addr1=0x1005, addr2=0x0000. BIP_EN rises the cycle after the third write.
- In RUN, assert BIP_HALT on the 10th RUN cycle with ACC=0x1234. Answer each TX_START with TX_DONE after 20 cycles -> TX bytes 34 12 0A 00; then STATE=0 and addr=0.
- DEPTH=4, send 4 non-halt words -> writes to addr0..3, then RUN without waiting for a halt word.
- Send byte 0xAA, assert RESET for 1 cycle, then send 00 00 -> single write to addr0 with data 0x0000; 0xAA is not present in any write.
- Pulse RX_DONE 3 times during RUN and TX_WAIT -> no MEM_WE, no state change. After the sequence completes, the next load starts at addr0.
- Hold RUN for 70000 cycles, then halt -> cycle bytes FF FF (saturated). TX_DATA is stable throughout each TX_WAIT.
